// File: rtl/dm_lat_mem.sv
// Data memory for the MEM stage with configurable depth and access latency.
// Req/Ready handshake; word/half/byte accesses; misaligned or out-of-range accesses raise AddrErr.
module dm_lat_mem #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 1,
    parameter bit LOG_EN    = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic        MemWrite,
    input  logic [1:0]  OpWidth,
    input  logic        LoadSigned,
    input  logic [31:0] WPC,
    output logic        Busy,
    output logic        Ready,
    output logic [31:0] RD,
    output logic        AddrErr
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        logic [1:0]  width;
        logic        sgn;
        logic [31:0] pc;
    } req_t;

    logic [31:0] mem [DEPTH];
    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    req_t        req_q, req_in, cur;
    logic        accept, commit;
    logic [31:0] cur_word, merged, done_word;

    function automatic logic addr_err(input req_t r);
        return (r.width == 2'b11)
            || (r.width == 2'b00 && r.addr[1:0] != 2'b00)
            || (r.width == 2'b01 && r.addr[0])
            || ((r.addr >> (ADDR_BITS + 2)) != 32'd0);
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old, input req_t r);
        logic [31:0] w;
        w = old;
        case (r.width)
            2'b00:   w = r.wd;
            2'b01:   if (r.addr[1]) w[31:16] = r.wd[15:0];
                     else           w[15:0]  = r.wd[15:0];
            default: w[{r.addr[1:0], 3'b000} +: 8] = r.wd[7:0];
        endcase
        return w;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input req_t r);
        logic [15:0] h;
        logic [7:0]  b;
        h = r.addr[1] ? w[31:16] : w[15:0];
        b = w[{r.addr[1:0], 3'b000} +: 8];
        case (r.width)
            2'b00:   return w;
            2'b01:   return r.sgn ? {{16{h[15]}}, h} : {16'h0000, h};
            default: return r.sgn ? {{24{b[7]}}, b} : {24'h000000, b};
        endcase
    endfunction

    assign req_in = '{addr: Addr, wd: WD, we: MemWrite, width: OpWidth, sgn: LoadSigned, pc: WPC};

    // With LATENCY=1 the store commits on the accept edge itself, before req_q holds the request.
    assign cur      = (state == S_WAIT) ? req_q : req_in;
    assign cur_word = mem[cur.addr[ADDR_BITS+1:2]];
    assign merged   = merge_lanes(cur_word, cur);
    assign accept   = Req && (state == S_IDLE || state == S_DONE);

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_WAIT: begin
                if (cnt == 4'd1) state_n = S_DONE;
                else             cnt_n   = cnt - 4'd1;
            end
            default: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_n = S_IDLE;
                end
            end
        endcase
    end

    assign commit = (state_n == S_DONE) && (state != S_DONE || accept) && cur.we && !addr_err(cur);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of block order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            req_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) req_q <= req_in;
        end
    end

    // NOTE: the array is cleared on reset because software relies on zeroed memory; this costs a wide reset fan-out.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            mem[cur.addr[ADDR_BITS+1:2]] <= merged;
        end
    end

`ifndef SYNTHESIS
    generate
        if (LOG_EN) begin : g_log
            always_ff @(posedge Clk) begin
                if (!Reset && commit)
                    $display("%d@%h: *%h <= %h", $time, cur.pc, {cur.addr[31:2], 2'b00}, merged);
            end
        end
    endgenerate
`endif

    assign done_word = mem[req_q.addr[ADDR_BITS+1:2]];
    assign Busy      = (state == S_WAIT);
    assign Ready     = (state == S_DONE);
    assign AddrErr   = Ready && addr_err(req_q);
    assign RD        = (Ready && !req_q.we && !AddrErr) ? extract(done_word, req_q) : 32'd0;

endmodule

// File: tb/tb_dm_lat_mem.sv
// Directed bench for dm_lat_mem with LATENCY=3: handshake timing, lane merging,
// sign/zero extension, address errors, reset abort and back-to-back accepts.
module tb_dm_lat_mem;

    localparam int LAT = 3;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Req = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WD = '0;
    logic        MemWrite = 1'b0;
    logic [1:0]  OpWidth = 2'b00;
    logic        LoadSigned = 1'b0;
    logic [31:0] WPC = '0;
    logic        Busy, Ready, AddrErr;
    logic [31:0] RD;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_rd;
    logic        got_err;
    int          got_lat, got_busy;

    dm_lat_mem #(.ADDR_BITS(12), .LATENCY(LAT), .LOG_EN(1)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Addr(Addr), .WD(WD),
        .MemWrite(MemWrite), .OpWidth(OpWidth), .LoadSigned(LoadSigned), .WPC(WPC),
        .Busy(Busy), .Ready(Ready), .RD(RD), .AddrErr(AddrErr)
    );

    always #5 Clk = ~Clk;

    // One access; inputs are scrambled right after the accept edge. got_lat=0 means no Ready seen.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic we,
                          input logic [1:0] w, input logic sg);
        @(negedge Clk);
        Req = 1'b1; Addr = a; WD = d; MemWrite = we; OpWidth = w; LoadSigned = sg; WPC = WPC + 4;
        @(posedge Clk);
        #1;
        Req = 1'b0; Addr = 32'hFFFF_FFFF; WD = 32'hA5A5_A5A5; MemWrite = ~we; OpWidth = 2'b11;
        got_lat = 0; got_busy = 0; got_rd = 'x; got_err = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            if (Busy) got_busy++;
            if (Ready) begin
                got_lat = i; got_rd = RD; got_err = AddrErr;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge Clk);
        Reset = 1'b1; Req = 1'b1;
        @(negedge Clk);
        checks++;
        if ({Busy, Ready, AddrErr} !== 3'b000 || RD !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: Busy=%b Ready=%b AddrErr=%b RD=%h, expected all 0", Busy, Ready, AddrErr, RD);
        end
        Reset = 1'b0; Req = 1'b0;
        access(32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (got_lat !== LAT || got_rd !== 32'd0 || got_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_load0: lat=%0d RD=%h err=%b, expected lat=%0d RD=0 err=0", got_lat, got_rd, got_err, LAT);
        end
    endtask

    task automatic test_word;
        access(32'h10, 32'hDEAD_BEEF, 1'b1, 2'b00, 1'b0);
        checks++;
        if (got_busy !== 2 || got_lat !== LAT || got_err !== 1'b0) begin
            errors++;
            $display("FAIL word_store_timing: busy=%0d lat=%0d err=%b, expected busy=2 lat=3 err=0", got_busy, got_lat, got_err);
        end
        @(negedge Clk);
        checks++;
        if (Ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_single_pulse: Ready=%b, expected 0", Ready);
        end
        access(32'h10, 32'h0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (got_rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL word_load: RD=%h, expected deadbeef", got_rd);
        end
    endtask

    task automatic test_byte;
        access(32'h13, 32'h0000_0081, 1'b1, 2'b10, 1'b0);
        access(32'h13, 32'h0, 1'b0, 2'b10, 1'b1);
        checks++;
        if (got_rd !== 32'hFFFF_FF81) begin
            errors++;
            $display("FAIL byte_signed: RD=%h, expected ffffff81", got_rd);
        end
        access(32'h13, 32'h0, 1'b0, 2'b10, 1'b0);
        checks++;
        if (got_rd !== 32'h0000_0081) begin
            errors++;
            $display("FAIL byte_unsigned: RD=%h, expected 00000081", got_rd);
        end
        access(32'h10, 32'h0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (got_rd !== 32'h81AD_BEEF) begin
            errors++;
            $display("FAIL byte_merge: RD=%h, expected 81adbeef", got_rd);
        end
    endtask

    task automatic test_half;
        access(32'h20, 32'h1111_2222, 1'b1, 2'b00, 1'b0);
        access(32'h22, 32'h0000_8000, 1'b1, 2'b01, 1'b0);
        access(32'h20, 32'h0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (got_rd !== 32'h8000_2222) begin
            errors++;
            $display("FAIL half_merge: RD=%h, expected 80002222", got_rd);
        end
        access(32'h22, 32'h0, 1'b0, 2'b01, 1'b1);
        checks++;
        if (got_rd !== 32'hFFFF_8000) begin
            errors++;
            $display("FAIL half_signed: RD=%h, expected ffff8000", got_rd);
        end
        access(32'h20, 32'h0, 1'b0, 2'b01, 1'b1);
        checks++;
        if (got_rd !== 32'h0000_2222) begin
            errors++;
            $display("FAIL half_low: RD=%h, expected 00002222", got_rd);
        end
    endtask

    task automatic test_errors;
        access(32'h6, 32'h0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (got_err !== 1'b1 || got_rd !== 32'd0 || got_lat !== LAT) begin
            errors++;
            $display("FAIL err_word_misaligned: err=%b RD=%h lat=%0d, expected err=1 RD=0 lat=3", got_err, got_rd, got_lat);
        end
        access(32'h5, 32'h0000_FFFF, 1'b1, 2'b01, 1'b0);
        checks++;
        if (got_err !== 1'b1 || got_rd !== 32'd0) begin
            errors++;
            $display("FAIL err_half_misaligned: err=%b RD=%h, expected err=1 RD=0", got_err, got_rd);
        end
        access(32'h4, 32'h0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (got_err !== 1'b0 || got_rd !== 32'd0) begin
            errors++;
            $display("FAIL err_half_nowrite: err=%b RD=%h, expected err=0 RD=0", got_err, got_rd);
        end
        access(32'h10, 32'h1234_5678, 1'b1, 2'b11, 1'b0);
        checks++;
        if (got_err !== 1'b1 || got_rd !== 32'd0) begin
            errors++;
            $display("FAIL err_opwidth: err=%b RD=%h, expected err=1 RD=0", got_err, got_rd);
        end
        access(32'h0001_0000, 32'hCAFE_F00D, 1'b1, 2'b00, 1'b0);
        checks++;
        if (got_err !== 1'b1 || got_rd !== 32'd0) begin
            errors++;
            $display("FAIL err_range: err=%b RD=%h, expected err=1 RD=0", got_err, got_rd);
        end
        access(32'h10, 32'h0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (got_rd !== 32'h81AD_BEEF) begin
            errors++;
            $display("FAIL err_nowrite_10: RD=%h, expected 81adbeef", got_rd);
        end
        access(32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (got_rd !== 32'd0) begin
            errors++;
            $display("FAIL err_nowrap_0: RD=%h, expected 00000000", got_rd);
        end
    endtask

    task automatic test_reset_abort;
        int seen;
        @(negedge Clk);
        Req = 1'b1; Addr = 32'h40; WD = 32'hDEAD_BEEF; MemWrite = 1'b1; OpWidth = 2'b00;
        @(posedge Clk);
        #1;
        Req = 1'b0;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: Busy=%b, expected 1", Busy);
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (Ready || Busy) seen++;
            @(negedge Clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_ready: active cycles=%0d, expected 0", seen);
        end
        access(32'h40, 32'h0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (got_rd !== 32'd0) begin
            errors++;
            $display("FAIL abort_no_write: RD=%h, expected 00000000", got_rd);
        end
        access(32'h10, 32'h0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (got_rd !== 32'd0) begin
            errors++;
            $display("FAIL reset_clears_mem: RD=%h, expected 00000000", got_rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  ready_map;
        logic [31:0] rd_at6;
        ready_map = '0;
        rd_at6 = '0;
        @(negedge Clk);
        Req = 1'b1; Addr = 32'h44; WD = 32'h1234_5678; MemWrite = 1'b1; OpWidth = 2'b00; LoadSigned = 1'b0;
        @(posedge Clk);
        #1;
        Addr = 32'hFFFF_FFFF; WD = 32'h0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge Clk);
            ready_map[k] = Ready;
            if (k == 2) begin
                Addr = 32'h0; MemWrite = 1'b1;
            end
            if (k == 3) begin
                Addr = 32'h44; MemWrite = 1'b0;
            end
            if (k == 6) begin
                rd_at6 = RD;
                Req = 1'b0;
            end
        end
        checks++;
        if (ready_map !== 8'b0100_1000) begin
            errors++;
            $display("FAIL b2b_ready_pattern: map=%b, expected 01001000", ready_map);
        end
        checks++;
        if (rd_at6 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL b2b_load_data: RD=%h, expected 12345678", rd_at6);
        end
        access(32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (got_rd !== 32'd0) begin
            errors++;
            $display("FAIL wait_req_ignored: RD=%h, expected 00000000", got_rd);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
